// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, capture FSM encoding, pixel and address types for the VGA capture path.
package vga_timing_pkg;

  localparam int DEF_H_TOTAL = 800;
  localparam int DEF_V_TOTAL = 526;
  localparam int DEF_HSYNC_W = 96;
  localparam int DEF_H_START = 145;
  localparam int DEF_V_START = 36;
  localparam int DEF_IMG_W   = 256;
  localparam int DEF_IMG_H   = 256;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] cap_addr_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    VERIFY   = 2'd1,
    IDLE     = 2'd2,
    CAPTURE  = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // Linear word address of an image pixel, row-major.
  function automatic cap_addr_t pix_addr(input logic [9:0] row, input logic [10:0] col,
                                         input int img_w);
    return cap_addr_t'(row) * cap_addr_t'(img_w) + cap_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Video input and memory-write bundle of the frame grabber; master = video source / memory side.
interface vga_frame_capture_if;
  import vga_timing_pkg::*;

  logic       vga_hsync;
  logic       vga_vsync;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       capture_en;
  logic       wr_en;
  cap_addr_t  DataAdrCap;
  logic [31:0] wr_data;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  modport master (
    output vga_hsync, vga_vsync, vga_r, vga_g, vga_b, capture_en,
    input  wr_en, DataAdrCap, wr_data, locked, frame_done, sync_err
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b, capture_en,
    output wr_en, DataAdrCap, wr_data, locked, frame_done, sync_err
  );

endinterface

// File: rtl/vga_timing_tracker.sv
// Registers the incoming sync/pixel stream, recovers x/y raster position and flags timing violations.
// VGA_CAPTURE_RGB_EN: when defined, green and blue are registered as well as red.
module vga_timing_tracker
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HSYNC_W = DEF_HSYNC_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic [10:0] o_x_cnt,
  output logic [9:0]  o_y_cnt,
  output logic        o_vrise,
  output pix_t        o_pix_q,
  output logic        o_viol
);

  localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_TIMEOUT = 11'(H_TOTAL + 16);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_WIDTH  = 11'(HSYNC_W);

  logic        r_h_q;
  logic        r_v_q;
  logic        r_h_prev;
  logic        r_v_prev;
  logic [10:0] r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic [10:0] r_hw_cnt;

  logic        w_hrise;
  logic        w_vrise;
  logic        w_hfall;

  assign w_hrise = r_h_q & ~r_h_prev;
  assign w_vrise = r_v_q & ~r_v_prev;
  assign w_hfall = ~r_h_q & r_h_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_q    <= 1'b0;
      r_v_q    <= 1'b0;
      r_h_prev <= 1'b0;
      r_v_prev <= 1'b0;
      r_x_cnt  <= '0;
      r_y_cnt  <= '0;
      r_hw_cnt <= '0;
    end else begin
      r_h_q    <= i_hsync;
      r_v_q    <= i_vsync;
      r_h_prev <= r_h_q;
      r_v_prev <= r_v_q;

      // A frame start realigns both counters even when hsync did not rise with it.
      if (w_hrise || w_vrise) begin
        r_x_cnt <= '0;
      end else if (r_x_cnt != 11'h7FF) begin
        r_x_cnt <= r_x_cnt + 11'd1;
      end

      if (w_vrise) begin
        r_y_cnt <= '0;
      end else if (w_hrise) begin
        r_y_cnt <= r_y_cnt + 10'd1;
      end

      // Counts h_q high cycles; equals the pulse width on the falling-edge cycle.
      if (w_hrise) begin
        r_hw_cnt <= 11'd1;
      end else if (r_h_q && (r_hw_cnt != 11'h7FF)) begin
        r_hw_cnt <= r_hw_cnt + 11'd1;
      end
    end
  end

`ifdef VGA_CAPTURE_RGB_EN
  pix_t r_pix_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_q <= '0;
    end else begin
      r_pix_q <= {i_r, i_g, i_b};
    end
  end

  assign o_pix_q = r_pix_q;
`else
  logic [7:0] r_pix_r;
  logic       w_unused_gb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_r <= '0;
    end else begin
      r_pix_r <= i_r;
    end
  end

  assign o_pix_q     = {r_pix_r, 16'h0000};
  assign w_unused_gb = ^{i_g, i_b};
`endif

  assign o_viol = (w_hrise && (r_x_cnt != X_LAST))
                | (!w_hrise && (r_x_cnt == X_TIMEOUT))
                | (w_vrise && (r_y_cnt != Y_LAST))
                | (w_hfall && (r_hw_cnt != HS_WIDTH));

  assign o_x_cnt = r_x_cnt;
  assign o_y_cnt = r_y_cnt;
  assign o_vrise = w_vrise;

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receive-side frame grabber: locks onto the sync stream and writes the active image to memory.
// VGA_CAPTURE_RGB_EN: when defined, writes {8'h00, r, g, b}; otherwise {24'h0, r}.
module vga_frame_capture
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HSYNC_W = DEF_HSYNC_W,
  parameter int H_START = DEF_H_START,
  parameter int V_START = DEF_V_START,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H
) (
  input logic                clk,
  input logic                reset,
  vga_frame_capture_if.slave cap_if
);

  localparam logic [10:0] X_LO     = 11'(H_START);
  localparam logic [10:0] X_HI     = 11'(H_START + IMG_W - 1);
  localparam logic [9:0]  Y_LO     = 10'(V_START);
  localparam logic [9:0]  Y_HI     = 10'(V_START + IMG_H - 1);
  localparam logic [10:0] COL_LAST = 11'(IMG_W - 1);
  localparam logic [9:0]  ROW_LAST = 10'(IMG_H - 1);

  logic [10:0] w_x_cnt;
  logic [9:0]  w_y_cnt;
  logic        w_vrise;
  logic        w_viol;
  pix_t        w_pix;
  logic [10:0] w_col;
  logic [9:0]  w_row;
  logic        w_win;
  logic        w_last;
  cap_addr_t   w_addr;
  logic [31:0] w_wdata;

  cap_state_t  r_state;
  logic        r_locked;
  logic        r_wr_en;
  cap_addr_t   r_addr;
  logic [31:0] r_wdata;
  logic        r_frame_done;
  logic        r_sync_err;

  vga_timing_tracker #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HSYNC_W (HSYNC_W)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_hsync (cap_if.vga_hsync),
    .i_vsync (cap_if.vga_vsync),
    .i_r     (cap_if.vga_r),
    .i_g     (cap_if.vga_g),
    .i_b     (cap_if.vga_b),
    .o_x_cnt (w_x_cnt),
    .o_y_cnt (w_y_cnt),
    .o_vrise (w_vrise),
    .o_pix_q (w_pix),
    .o_viol  (w_viol)
  );

  assign w_col  = w_x_cnt - X_LO;
  assign w_row  = w_y_cnt - Y_LO;
  assign w_win  = (r_state == CAPTURE)
                && (w_x_cnt >= X_LO) && (w_x_cnt <= X_HI)
                && (w_y_cnt >= Y_LO) && (w_y_cnt <= Y_HI);
  assign w_last = (w_col == COL_LAST) && (w_row == ROW_LAST);
  assign w_addr = pix_addr(w_row, w_col, IMG_W);

`ifdef VGA_CAPTURE_RGB_EN
  assign w_wdata = {8'h00, w_pix.r, w_pix.g, w_pix.b};
`else
  logic w_unused_gb;
  assign w_wdata     = {24'h0, w_pix.r};
  assign w_unused_gb = ^{w_pix.g, w_pix.b};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= UNLOCKED;
      r_locked     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_sync_err   <= w_viol;
      // A violation suppresses the write it coincides with, so no write follows the abort.
      r_wr_en      <= w_win && !w_viol;
      r_frame_done <= w_win && w_last && !w_viol;
      if (w_win) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end

      case (r_state)
        UNLOCKED: begin
          r_locked <= 1'b0;
          if (w_vrise) begin
            r_state <= VERIFY;
          end
        end
        VERIFY: begin
          if (w_viol) begin
            r_state <= UNLOCKED;
          end else if (w_vrise) begin
            r_state  <= IDLE;
            r_locked <= 1'b1;
          end
        end
        IDLE: begin
          if (w_viol) begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
          end else if (w_vrise && cap_if.capture_en) begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_viol) begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
          end else if (w_win && w_last) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= UNLOCKED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign cap_if.wr_en      = r_wr_en;
  assign cap_if.DataAdrCap = r_addr;
  assign cap_if.wr_data    = r_wdata;
  assign cap_if.locked     = r_locked;
  assign cap_if.frame_done = r_frame_done;
  assign cap_if.sync_err   = r_sync_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced raster (40x24 clocks, 16x8 image) with a write scoreboard.
module tb_vga_frame_capture;

  localparam int H_T = 40;
  localparam int V_T = 24;
  localparam int HSW = 4;
  localparam int H_S = 10;
  localparam int V_S = 3;
  localparam int IW  = 16;
  localparam int IH  = 8;
  localparam logic [31:0] LAST_ADDR = 32'(IW * IH - 1);

`ifdef VGA_CAPTURE_RGB_EN
  localparam bit RGB_BUILD = 1'b1;
`else
  localparam bit RGB_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk;
  logic reset;
  vga_frame_capture_if bus ();

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          fd_cnt = 0;
  int          se_cnt = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_data = 0;

  vga_frame_capture #(
    .H_TOTAL (H_T),
    .V_TOTAL (V_T),
    .HSYNC_W (HSW),
    .H_START (H_S),
    .V_START (V_S),
    .IMG_W   (IW),
    .IMG_H   (IH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cap_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [31:0] rgb;
    rgb = {8'h00, r, g, b};
    return RGB_BUILD ? rgb : {24'h0, rgb[23:16]};
  endfunction

  // Pixel driven at index i of a line maps to col i-H_S-1 (two register stages before x_cnt aligns).
  task automatic drive_frame(input bit cap, input int mode, input int short_line,
                             input int stop_line, input int cen_line);
    for (int L = 0; L < V_T; L++) begin
      int line_len;
      if (L == stop_line) return;
      if (L == cen_line) bus.capture_en = 1'b1;
      line_len = (L == short_line) ? H_T - 1 : H_T;
      for (int i = 0; i < line_len; i++) begin
        int col;
        int row;
        bit in_win;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        col    = i - H_S - 1;
        row    = L - V_S;
        in_win = (col >= 0) && (col < IW) && (row >= 0) && (row < IH);
        if (!in_win) begin
          r = 8'hEE; g = 8'hDD; b = 8'hCC;
        end else if (mode == 0) begin
          r = 8'(col ^ row); g = 8'(col + row); b = 8'(row * 3);
        end else begin
          r = 8'h12; g = 8'h34; b = 8'h56;
        end
        @(negedge clk);
        bus.vga_hsync = (i < HSW);
        bus.vga_vsync = (L < 2);
        bus.vga_r     = r;
        bus.vga_g     = g;
        bus.vga_b     = b;
        if (cap && in_win && ((short_line < 0) || (L <= short_line)))
          exp_q.push_back('{addr: 32'(row * IW + col), data: exp_data(r, g, b),
                            cyc: cyc + 32'd2});
      end
    end
  endtask

  task automatic end_frame(input string tag, input int exp_wr, input int exp_fd,
                           input int exp_se, input logic exp_lk);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_wr_count"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, "_frame_done_count"}, 32'(fd_cnt), 32'(exp_fd));
    if (exp_se >= 0) chk({tag, "_sync_err_cycles"}, 32'(se_cnt), 32'(exp_se));
    chk({tag, "_locked"}, 32'(bus.locked), 32'(exp_lk));
    exp_q.delete();
    wr_cnt = 0;
    fd_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_addr"}, bus.DataAdrCap, 32'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_sync_err"}, 32'(bus.sync_err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_data = bus.wr_data;
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.DataAdrCap, mon_e.addr);
        chk("wr_data", bus.wr_data, mon_e.data);
        chk("wr_latency", cyc, mon_e.cyc);
      end
    end
    if (bus.frame_done === 1'b1) begin
      fd_cnt++;
      chk("frame_done_on_last_write", (bus.wr_en === 1'b1) ? bus.DataAdrCap : 32'hFFFF_FFFF,
          LAST_ADDR);
    end
    if (bus.sync_err === 1'b1) se_cnt++;
  end

  initial begin
    reset          = 1'b0;
    bus.vga_hsync  = 1'b0;
    bus.vga_vsync  = 1'b0;
    bus.vga_r      = 8'h00;
    bus.vga_g      = 8'h00;
    bus.vga_b      = 8'h00;
    bus.capture_en = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Lock sequence: VERIFY after the 1st vrise, locked at the 2nd, capture from the 3rd.
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f1_verify", 0, 0, -1, 1'b0);
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f2_locked", 0, 0, 0, 1'b1);
    drive_frame(1'b1, 0, -1, -1, -1);
    end_frame("f3_ramp_capture", IW * IH, 1, 0, 1'b1);

    // Arm request low at vrise, raised mid-frame: capture only on the following frame.
    bus.capture_en = 1'b0;
    drive_frame(1'b0, 1, -1, -1, 5);
    end_frame("f4_not_armed", 0, 0, 0, 1'b1);
    drive_frame(1'b1, 1, -1, -1, -1);
    chk("f5_rgb_word", last_data, RGB_BUILD ? 32'h0012_3456 : 32'h0000_0012);
    end_frame("f5_rgb_capture", IW * IH, 1, 0, 1'b1);

    // 39-clock line in image row 1 aborts the capture; relock takes two clean vrises.
    drive_frame(1'b1, 0, V_S + 1, -1, -1);
    end_frame("f6_abort", 2 * IW, 0, 1, 1'b0);
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f7_reverify", 0, 0, 0, 1'b0);
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f8_relocked", 0, 0, 0, 1'b1);
    drive_frame(1'b1, 0, -1, -1, -1);
    end_frame("f9_recapture", IW * IH, 1, 0, 1'b1);

    // Reset during capture at image row 4.
    drive_frame(1'b1, 0, -1, V_S + 4, -1);
    end_frame("f10_before_reset", 4 * IW, 0, 0, 1'b1);
    chk("f10_addr_nonzero", 32'(bus.DataAdrCap != 32'd0), 32'd1);
    @(negedge clk);
    reset         = 1'b0;
    bus.vga_hsync = 1'b0;
    bus.vga_vsync = 1'b0;
    #1;
    check_zero("midcap_reset");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f11_after_reset", 0, 0, -1, 1'b0);
    drive_frame(1'b0, 0, -1, -1, -1);
    end_frame("f12_after_reset", 0, 0, 0, 1'b1);
    drive_frame(1'b1, 0, -1, -1, -1);
    end_frame("f13_after_reset", IW * IH, 1, 0, 1'b1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
